// File: rtl/date_from_day_number.sv
// Iterative day-number to Gregorian date converter: strips 400-year blocks,
// then whole years, then whole months, one subtraction per cycle.
module date_from_day_number #(
  parameter int DAY_W   = 23,
  parameter int MAX_DAY = 5983767
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DAY_W-1:0] day_num,
  output logic             busy,
  output logic             valid,
  output logic             err,
  output logic [22:0]      date,
  output logic [2:0]       weekday
);

  // state  | meaning
  // IDLE   | waiting for start; outputs hold the last result
  // STRIDE | removing whole 146097-day (400-year) blocks
  // YEAR   | removing whole years
  // MONTH  | removing whole months, then publishing the date
  // ERR    | out-of-range request; publishes err on the next edge
  typedef enum logic [2:0] {
    S_IDLE, S_STRIDE, S_YEAR, S_MONTH, S_ERR
  } state_t;

  localparam logic [DAY_W-1:0] STRIDE_DAYS = DAY_W'(146097);

  state_t           state_q, state_d;
  logic [DAY_W-1:0] rem_q, rem_d;
  logic [13:0]      year_q, year_d;
  logic [3:0]       month_q, month_d;
  logic [2:0]       wd_q, wd_d;

  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [22:0]      date_q, date_d;
  logic [2:0]       weekday_q, weekday_d;

  function automatic logic is_leap(input logic [13:0] y);
    return ((y[1:0] == 2'd0) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                    return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  logic             leap_cur;
  logic [8:0]       ylen;
  logic [4:0]       mlen;
  logic             in_range;
  logic [2:0]       day_mod7;
  logic             more_stride, more_year, more_month;

  always_comb begin
    leap_cur    = is_leap(year_q);
    ylen        = leap_cur ? 9'd366 : 9'd365;
    mlen        = month_len(month_q, leap_cur);
    in_range    = (day_num != '0) && (day_num <= DAY_W'(MAX_DAY));
    day_mod7    = 3'(day_num % DAY_W'(7));
    more_stride = rem_q > STRIDE_DAYS;
    more_year   = rem_q > DAY_W'(ylen);
    more_month  = rem_q > DAY_W'(mlen);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      year_q    <= '0;
      month_q   <= '0;
      wd_q      <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      date_q    <= '0;
      weekday_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      year_q    <= year_d;
      month_q   <= month_d;
      wd_q      <= wd_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      date_q    <= date_d;
      weekday_q <= weekday_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    year_d  = year_q;
    month_d = month_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (in_range) begin
            rem_d   = day_num;
            year_d  = 14'd1;
            month_d = 4'd1;
            wd_d    = day_mod7;
            state_d = S_STRIDE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_STRIDE: begin
        if (more_stride) begin
          rem_d  = rem_q - STRIDE_DAYS;
          year_d = year_q + 14'd400;
        end else begin
          state_d = S_YEAR;
        end
      end
      S_YEAR: begin
        if (more_year) begin
          rem_d  = rem_q - DAY_W'(ylen);
          year_d = year_q + 14'd1;
        end else begin
          state_d = S_MONTH;
        end
      end
      S_MONTH: begin
        if (more_month) begin
          rem_d   = rem_q - DAY_W'(mlen);
          month_d = month_q + 4'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result registers only change on the edge that raises valid.
  always_comb begin
    valid_d   = 1'b0;
    err_d     = err_q;
    date_d    = date_q;
    weekday_d = weekday_q;
    if (state_q == S_ERR) begin
      valid_d   = 1'b1;
      err_d     = 1'b1;
      date_d    = '0;
      weekday_d = '0;
    end else if (state_q == S_MONTH && !more_month) begin
      valid_d   = 1'b1;
      err_d     = 1'b0;
      date_d    = {year_q, month_q, rem_q[4:0]};
      weekday_d = wd_q;
    end
  end

  assign busy    = (state_q == S_STRIDE) || (state_q == S_YEAR) || (state_q == S_MONTH);
  assign valid   = valid_q;
  assign err     = err_q;
  assign date    = date_q;
  assign weekday = weekday_q;

endmodule
